// File: rtl/sent_cfg_sched.sv
// sent_cfg_sched - configuration scheduler between the SENT parameter parser
// and the per-channel SENT transmitters.
//
// Parsed records are queued, validated one at a time and handed to their
// target channel only while that channel reports a frame boundary
// (ch_cfg_ready). Invalid records, records that wait too long and records
// that arrive at a full queue are dropped and counted.
//
// Ports:
//   clk, rst        module clock, asynchronous active-high reset
//   cfg_vld         one-cycle strobe, record present on cfg_channel/cfg_param
//   cfg_channel     target channel index
//   cfg_param       {ctick[7:0], ltick[7:0], pause_mode[1:0], pause_len[15:0],
//                    crc_mode, status_nibble[3:0], data_len[2:0], data[23:0]}
//   ch_cfg_ready    per-channel "between frames" indication
//   ch_cfg_vld      one-hot, one-cycle delivery strobe
//   ch_cfg_param    delivered record, held after the strobe
//   ovf_cnt         records lost to a full queue (saturating)
//   inv_cnt         records rejected by validation (saturating)
//   tmo_cnt         records dropped after waiting TIMEOUT cycles (saturating)
//   busy            queue non-empty or a record in flight
module sent_cfg_sched #(
    parameter int          CH_NUM     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_vld,
    input  logic [7:0]          cfg_channel,
    input  logic [65:0]         cfg_param,
    input  logic [CH_NUM-1:0]   ch_cfg_ready,
    output logic [CH_NUM-1:0]   ch_cfg_vld,
    output logic [65:0]         ch_cfg_param,
    output logic [7:0]          ovf_cnt,
    output logic [7:0]          inv_cnt,
    output logic [7:0]          tmo_cnt,
    output logic                busy
);

    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]   CH_C    = 8'(CH_NUM);

    typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;

    // Record queue: {channel, param}
    logic [73:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, wr_en, pop;

    state_t        state, state_n;
    logic [7:0]    hold_ch;
    logic [65:0]   hold_param;
    logic [31:0]   timer;
    logic [CH_NUM-1:0] ch_sel;
    logic          ready_sel, invalid;
    logic          latch, deliver, timer_clr, timer_inc, inv_inc, tmo_inc;

    // Fields of the held record
    logic [7:0]  ctick, ltick;
    logic [1:0]  pause_mode;
    logic [15:0] pause_len;
    logic [2:0]  data_len;

    assign ctick      = hold_param[65:58];
    assign ltick      = hold_param[57:50];
    assign pause_mode = hold_param[49:48];
    assign pause_len  = hold_param[47:32];
    assign data_len   = hold_param[26:24];

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // A full queue still accepts a record when the head leaves on the same edge.
    assign wr_en = cfg_vld && (!full || pop);
    assign busy  = !empty || (state != IDLE);

    always_comb begin
        invalid = (hold_ch >= CH_C)
               || (ctick < 8'd3) || (ctick > 8'd90)
               || (ltick < 8'd4)
               || (pause_mode == 2'd3)
               || (data_len == 3'd0) || (data_len > 3'd6)
               || ((pause_mode != 2'd0) &&
                   ((pause_len < 16'd12) || (pause_len > 16'd768)));
    end

    // One-hot decode of the held channel; only meaningful once validated.
    always_comb begin
        ch_sel = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (hold_ch == 8'(i)) ch_sel[i] = 1'b1;
        end
        ready_sel = |(ch_sel & ch_cfg_ready);
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        latch     = 1'b0;
        deliver   = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        inv_inc   = 1'b0;
        tmo_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    latch   = 1'b1;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (invalid) begin
                    pop     = 1'b1;
                    inv_inc = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_clr = 1'b1;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                // Ready wins over a timeout landing in the same cycle.
                if (ready_sel) begin
                    deliver = 1'b1;
                    pop     = 1'b1;
                    state_n = IDLE;
                end else if (timer == TIMEOUT - 32'd1) begin
                    pop     = 1'b1;
                    tmo_inc = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {cfg_channel, cfg_param};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_ch      <= '0;
            hold_param   <= '0;
            timer        <= '0;
            ch_cfg_vld   <= '0;
            ch_cfg_param <= '0;
            ovf_cnt      <= '0;
            inv_cnt      <= '0;
            tmo_cnt      <= '0;
        end else begin
            state <= state_n;
            if (latch) {hold_ch, hold_param} <= mem[rd_ptr];
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 32'd1;
            ch_cfg_vld <= deliver ? ch_sel : '0;
            if (deliver) ch_cfg_param <= hold_param;
            if (cfg_vld && !wr_en && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            if (inv_inc && inv_cnt != 8'hFF)           inv_cnt <= inv_cnt + 8'd1;
            if (tmo_inc && tmo_cnt != 8'hFF)           tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

endmodule
